// File: rtl/alu_exec_pkg.sv
// Shared constants, instruction layout and FSM states for the accumulator
// decode/execute sequencer.
package alu_exec_pkg;

  localparam int OPC_W  = 2;
  localparam int RD_W   = 3;
  localparam int IMMF_W = 3;
  localparam int OPC_LO = 6;
  localparam int RD_LO  = 3;
  localparam int IMM_LO = 0;

  localparam logic [1:0] OP_LI   = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] CTRL_LI   = 2'b00;
  localparam logic [1:0] CTRL_ADDI = 2'b01;
  localparam logic [1:0] CTRL_IDLE = 2'b11;

  // Field order mirrors the instruction word, MSB first.
  typedef struct packed {
    logic [OPC_W-1:0]  op;
    logic [RD_W-1:0]   rd;
    logic [IMMF_W-1:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  function automatic logic writes_rd(input logic [1:0] op);
    return (op == OP_LI) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// Architectural register file: one write port, operand and debug read ports.
// ALU_EXEC_R0_ZERO_EN hardwires r0 to zero.
module alu_exec_regfile
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_d,
  output logic [DATA_W-1:0] rdata_d
);

  localparam int NREGS = 1 << REG_AW;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         we_eff;

`ifdef ALU_EXEC_R0_ZERO_EN
  assign we_eff  = we && (waddr != '0);
  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_d = (raddr_d == '0) ? '0 : regs[raddr_d];
`else
  assign we_eff  = we;
  assign rdata_a = regs[raddr_a];
  assign rdata_d = regs[raddr_d];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         regs <= '0;
    else if (we_eff) regs[waddr] <= wdata;
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Four-cycle decode/execute sequencer driving an external combinational ALU.
// Optional ALU_EXEC_R0_ZERO_EN makes r0 a constant-zero register.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state, state_nxt;
  instr_t            instr_q;
  logic [DATA_W-1:0] wb_q;
  logic [DATA_W-1:0] rd_val;
  logic              rf_we;

  // Ready depends on state only; no path from instr_valid.
  assign instr_ready = (state == S_IDLE) && !rst;
  assign done        = (state == S_WB);
  assign rf_we       = (state == S_WB) && writes_rd(instr_q.op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (instr_q.op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= CTRL_IDLE;
      wb_q     <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid) instr_q <= instr_t'(instr);
        S_DECODE: begin
          alu_a <= rd_val;
          alu_b <= {{(DATA_W-IMM_W){1'b0}}, instr_q.imm};
          case (instr_q.op)
            OP_LI:   alu_ctrl <= CTRL_LI;
            OP_ADDI: alu_ctrl <= CTRL_ADDI;
            default: alu_ctrl <= CTRL_IDLE;
          endcase
          if (instr_q.op == OP_HALT) halted <= 1'b1;
        end
        S_EXEC:  wb_q <= alu_result;
        S_WB:    alu_ctrl <= CTRL_IDLE;
        default: ;
      endcase
    end
  end

  alu_exec_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (instr_q.rd),
    .wdata   (wb_q),
    .raddr_a (instr_q.rd),
    .rdata_a (rd_val),
    .raddr_d (dbg_addr),
    .rdata_d (dbg_data)
  );

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural combinational ALU.
module tb_alu_exec_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] alu_a, alu_b, alu_result, dbg_data;
  logic [1:0] alu_ctrl;
  logic       done, halted;
  logic [2:0] dbg_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] ex_ctrl;
  logic [7:0] ex_a, ex_b;

  always #5 clk = ~clk;

  // External ALU: sign-extends the 3-bit immediate.
  always_comb begin
    logic [7:0] sx;
    sx = {{5{alu_b[2]}}, alu_b[2:0]};
    case (alu_ctrl)
      2'b00:   alu_result = sx;
      2'b01:   alu_result = alu_a + sx;
      default: alu_result = 8'h00;
    endcase
  end

  alu_exec_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .done        (done),
    .halted      (halted),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, e);
  endtask

  // Issues one instruction from IDLE and checks the 4-cycle cadence.
  task automatic run_instr(input string tag, input logic [7:0] ins);
    logic [7:0] pre;
    int w;
    dbg_addr = ins[5:3];
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 16) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".rdy_in"}, instr_ready, 1);
    pre = dbg_data;
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, ".rdy_dec"}, instr_ready, 0);
    @(negedge clk);
    ex_ctrl = alu_ctrl;
    ex_a = alu_a;
    ex_b = alu_b;
    chk({tag, ".done_ex"}, done, 0);
    @(negedge clk);
    chk({tag, ".done_wb"}, done, 1);
    chk({tag, ".rdy_wb"}, instr_ready, 0);
    chk({tag, ".dbg_old"}, dbg_data, pre);
    @(negedge clk);
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".rdy_out"}, instr_ready, 1);
  endtask

  initial begin
    int xfers, dones, ready_seen, done_seen;
    int xcyc[4];
    logic pend;

    rst = 1'b1;
    instr = 8'h00;
    instr_valid = 1'b0;
    dbg_addr = 3'd0;
    #1;
    chk("rst.rdy", instr_ready, 0);
    chk("rst.ctrl", alu_ctrl, 2'b11);
    chk("rst.a", alu_a, 0);
    chk("rst.b", alu_b, 0);
    chk("rst.done", done, 0);
    chk("rst.halt", halted, 0);
    repeat (2) @(negedge clk);
    chk("rst.rdy_hold", instr_ready, 0);
    for (int i = 0; i < 8; i++) chk_reg($sformatf("rst.r%0d", i), 3'(i), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // LI r3,-2
    run_instr("li_r3", 8'h1E);
    chk("li_r3.ctrl", ex_ctrl, 2'b00);
    chk_reg("li_r3.val", 3'd3, 8'hFE);

    // ADDI r3,+3
    run_instr("addi_r3", 8'h5B);
    chk("addi_r3.ctrl", ex_ctrl, 2'b01);
    chk("addi_r3.a", ex_a, 8'hFE);
    chk("addi_r3.b", ex_b, 8'h03);
    chk_reg("addi_r3.val", 3'd3, 8'h01);

    // Wrap: LI r2,-1 then ADDI r2,+1
    run_instr("li_r2", 8'h17);
    chk_reg("li_r2.val", 3'd2, 8'hFF);
    run_instr("addi_r2", 8'h51);
    chk_reg("wrap.r2", 3'd2, 8'h00);
    chk_reg("wrap.r3", 3'd3, 8'h01);
    for (int i = 0; i < 8; i++)
      if (i != 2 && i != 3) chk_reg($sformatf("wrap.r%0d", i), 3'(i), 8'h00);

    // Backpressure: LI r1,+3 then ADDI r1,+3 with valid held
    @(negedge clk);
    instr = 8'h0B;
    instr_valid = 1'b1;
    xfers = 0;
    dones = 0;
    pend = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (done) dones++;
      if (pend) begin
        pend = 1'b0;
        if (xfers == 1) instr = 8'h4B;
        else instr_valid = 1'b0;
      end
      if (instr_valid && instr_ready) begin
        if (xfers < 4) xcyc[xfers] = c;
        xfers++;
        pend = 1'b1;
      end
    end
    instr_valid = 1'b0;
    chk("bp.xfers", xfers, 2);
    chk("bp.spacing", xcyc[1] - xcyc[0], 4);
    chk("bp.dones", dones, 2);
    chk_reg("bp.r1", 3'd1, 8'h06);

    // HALT
    @(negedge clk);
    chk("halt.rdy_in", instr_ready, 1);
    instr = 8'hC0;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("halt.t1", halted, 0);
    @(negedge clk);
    chk("halt.t2", halted, 1);
    instr = 8'h0B;
    instr_valid = 1'b1;
    ready_seen = 0;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (instr_ready) ready_seen++;
      if (done) done_seen++;
    end
    instr_valid = 1'b0;
    chk("halt.rdy", ready_seen, 0);
    chk("halt.done", done_seen, 0);
    chk("halt.sticky", halted, 1);
    chk_reg("halt.r1", 3'd1, 8'h06);
    chk_reg("halt.r3", 3'd3, 8'h01);
    chk_reg("halt.r2", 3'd2, 8'h00);
    rst = 1'b1;
    #1;
    chk("halt.rst_clr", halted, 0);
    chk_reg("halt.rst_r1", 3'd1, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Reset during S_EXEC of LI r5,+1
    @(negedge clk);
    instr = 8'h29;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort.ctrl_ex", alu_ctrl, 2'b00);
    rst = 1'b1;
    #1;
    chk("abort.rdy_rst", instr_ready, 0);
    chk("abort.ctrl_rst", alu_ctrl, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.rdy_first", instr_ready, 1);
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort.done", done_seen, 0);
    chk_reg("abort.r5", 3'd5, 8'h00);

    // LI r0,+1
    run_instr("li_r0", 8'h01);
`ifdef ALU_EXEC_R0_ZERO_EN
    chk_reg("r0.val", 3'd0, 8'h00);
`else
    chk_reg("r0.val", 3'd0, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle decode/execute sequencer for the 8-bit accumulator datapath.
- Accepts 8-bit instructions over a valid/ready handshake and holds the architectural register file.
- Drives the external ALU operand/control inputs (`alu_a`, `alu_b`, `alu_ctrl`), captures `alu_result`, and writes it back.
- It is the producer/consumer end of the ALU interface: the ALU stays purely combinational, and all sequencing lives here.

Parameters:
- DATA_W, 8, register and ALU data width.
- REG_AW, 3, register address width; register count = 2**REG_AW.
- IMM_W, 3, immediate field width; the ALU sign-extends it.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  8  instruction word, fields as below.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block can accept an instruction this cycle.
- alu_a  output  DATA_W  register operand to the ALU.
- alu_b  output  DATA_W  {zero-pad, instr[2:0]} immediate to the ALU.
- alu_ctrl  output  2  00 = load-immediate, 01 = add-immediate, 11 = idle (result 0).
- alu_result  input  DATA_W  combinational ALU output.
- done  output  1  one-cycle pulse when an instruction retires.
- halted  output  1  HALT executed; sticky until reset.
- dbg_addr  input  REG_AW  debug register-read address.
- dbg_data  output  DATA_W  register file contents at dbg_addr, combinational.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it is fixed as such.
- Instruction fields: [7:6] opcode, [5:3] rd, [2:0] imm.
  - Opcodes: 00 LI (rd = sext(imm)); 01 ADDI (rd = rd + sext(imm)); 10 NOP; 11 HALT.
- Reset values:
  - state = S_IDLE.
  - All registers = 0.
  - alu_a = 0, alu_b = 0, alu_ctrl = 2'b11.
  - done = 0, halted = 0.
  - instr_ready = 0 while rst is high.
- instr_ready = 1 only in S_IDLE with rst low. It is decoded from state, with no combinational path from instr_valid.
- Handshake: a transfer occurs on the rising edge where instr_valid && instr_ready. instr is latched into instr_q at that edge.
- FSM states and transitions:
  - S_IDLE: on transfer, go to S_DECODE; otherwise stay.
  - S_DECODE: register the ALU inputs, then go to S_EXEC.
    - alu_a <= reg[rd].
    - alu_b <= {5'b0, imm}.
    - alu_ctrl <= 00 for LI, 01 for ADDI, 11 for NOP.
    - HALT goes to S_HALT instead of S_EXEC and sets halted.
  - S_EXEC: wb_q <= alu_result; go to S_WB.
  - S_WB: if opcode is LI or ADDI, reg[rd] <= wb_q. NOP writes nothing. done = 1 for this cycle only. alu_ctrl <= 11. Go to S_IDLE.
  - S_HALT: absorbing state. instr_ready = 0, done = 0. Only rst exits.
- Timing and throughput:
  - Transfer at edge T; the register update is visible on dbg_data after edge T+3.
  - One instruction per 4 cycles; the next transfer is possible at edge T+4.
- Arithmetic: modulo 2**DATA_W. Overflow wraps silently; no flags.
- Backpressure: instr_valid held while busy is not consumed. The source must hold instr stable until the transfer edge.
- Reset mid-operation: the in-flight instruction is discarded with no register write. done never fires for it.
- dbg_data reads are independent of the FSM. On a read of the register being written in S_WB, dbg_data shows the old value until the edge.

Optional Feature:
- Macro: ALU_EXEC_R0_ZERO_EN.
- Defined:
  - reg[0] reads as 0 on both alu_a and dbg_data.
  - Writes to rd = 0 are dropped, but done still pulses.
- Undefined: reg[0] is an ordinary register.

Decomposition:
- Package alu_exec_pkg holds:
  - opcode constants OP_LI, OP_ADDI, OP_NOP, OP_HALT.
  - ALU ctrl constants CTRL_LI = 2'b00, CTRL_ADDI = 2'b01, CTRL_IDLE = 2'b11.
  - FSM state enum.
  - field-position localparams.
- Sub-module alu_exec_regfile:
  - 2**REG_AW x DATA_W storage.
  - Asynchronous reset to 0.
  - One synchronous write port.
  - Two combinational read ports: operand and debug.
  - Contains the R0_ZERO logic.

Test Plan:
- Reset then LI r3,-2 (instr 0x1E) -> instr_ready low 3 cycles; done pulses at T+3; dbg_addr = 3 reads 0xFE; alu_ctrl = 00 in S_EXEC.
- ADDI r3,+3 after the above (0x5B) -> r3 = 0x01; alu_a = 0xFE, alu_b = 0x03 in S_EXEC.
- Wrap-around: LI r2,-1 (0x17) then ADDI r2,+1 (0x51) -> r2 = 0x00; no other register changes.
- Backpressure: instr_valid held continuously with 0x0B, 0x4B queued -> exactly one transfer per 4 cycles; r1 ends 0x06; exactly two done pulses.
- HALT (0xC0) -> halted = 1 from T+2; instr_ready stays 0; a following 0x0B is never accepted; registers unchanged. Reset clears halted.
- Reset asserted in S_EXEC of LI r5,+1 (0x29) -> r5 stays 0; no done; instr_ready = 1 on the first cycle after rst deasserts. With ALU_EXEC_R0_ZERO_EN, LI r0,+1 (0x01) -> dbg r0 = 0, done pulses.
